// File: rtl/eth_pkg.sv
// eth_pkg: shared constants and FSM state type for the GMII receive framer.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned ETH_MIN_FRAME = 64;          // dest..FCS inclusive
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam int unsigned ETH_FCS_LEN   = 4;
  localparam int unsigned DLY_DEPTH     = ETH_FCS_LEN + 1;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    DROP
  } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-parallel CRC-32 (poly 0x04C11DB7, init all-ones). Data bits
// are consumed LSB first, so running it across a frame plus its FCS leaves
// the register at CRC_RESIDUE for an intact frame.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  // eight serial LFSR steps unrolled into one cycle
  always_comb begin
    crc_next = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_next[31] ^ data[i])
        crc_next = {crc_next[30:0], 1'b0} ^ CRC_POLY;
      else
        crc_next = {crc_next[30:0], 1'b0};
    end
  end

  // CRC register: preset on clear, advance on enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= '1;
    else if (clr) crc <= '1;
    else if (en)  crc <= crc_next;
  end

endmodule

// File: rtl/eth_rx_frame.sv
// eth_rx_frame: GMII receive framer. Strips preamble/SFD, filters on the
// destination MAC, captures the EtherType and delivers the payload with the
// trailing FCS removed through a 5-byte delay line.
// Build option: define ETH_RX_CRC_CHECK_EN to add FCS checking (crc32_d8).
module eth_rx_frame
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic [15:0] rx_eth_type,
  output logic [15:0] rx_byte_num,
  output logic        rx_done,
  output logic        rx_err
);

  rx_state_t       state, state_next;
  logic            armed;
  logic [2:0]      pre_cnt;
  logic [3:0]      hdr_cnt;
  logic [39:0]     hdr_sh;
  logic [47:0]     dest_now;
  logic            dest_ok;
  logic            sfd_ok;
  logic [4:0][7:0] dly;
  logic [2:0]      dly_cnt;
  logic            dly_full;
  logic [6:0]      frm_cnt;
  logic            runt;
  logic [15:0]     beat_cnt;
  logic            beat_sat;
  logic            sfd_hit, hdr_take, pay_take, pay_end;
  logic            beat, last_beat, crc_bad;

  assign dest_now  = {hdr_sh, gmii_rxd};
  assign dest_ok   = (dest_now == BOARD_MAC) || (dest_now == ETH_BCAST_MAC);
  assign sfd_ok    = gmii_rx_dv && (gmii_rxd == ETH_SFD) && (pre_cnt >= 3'd6);
  assign dly_full  = (dly_cnt == 3'(DLY_DEPTH));
  assign runt      = (frm_cnt < 7'(ETH_MIN_FRAME));
  assign beat      = (pay_take || pay_end) && dly_full;
  assign last_beat = pay_end && dly_full;

  // state register
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (gmii_rx_dv)
          state_next = (armed && gmii_rxd == ETH_PREAMBLE) ? PREAMBLE : DROP;
      PREAMBLE:
        if (!gmii_rx_dv)                   state_next = IDLE;
        else if (gmii_rxd == ETH_PREAMBLE) state_next = PREAMBLE;
        else if (sfd_ok)                   state_next = HEADER;
        else                               state_next = DROP;
      HEADER:
        if (!gmii_rx_dv)                      state_next = IDLE;
        else if (hdr_cnt == 4'd5 && !dest_ok) state_next = DROP;
        else if (hdr_cnt == 4'd13)            state_next = PAYLOAD;
      PAYLOAD:
        if (!gmii_rx_dv) state_next = IDLE;
      DROP:
        if (!gmii_rx_dv) state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  // per-state datapath strobes
  always_comb begin
    sfd_hit  = 1'b0;
    hdr_take = 1'b0;
    pay_take = 1'b0;
    pay_end  = 1'b0;
    case (state)
      PREAMBLE: sfd_hit  = sfd_ok;
      HEADER:   hdr_take = gmii_rx_dv;
      PAYLOAD: begin
        pay_take = gmii_rx_dv;
        pay_end  = !gmii_rx_dv;
      end
      default: ;
    endcase
  end

  // after reset, frames are accepted only once dv has been seen low
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst)             armed <= 1'b0;
    else if (!gmii_rx_dv) armed <= 1'b1;
  end

  // preamble length counter, saturating at 7
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst)
      pre_cnt <= '0;
    else if (state == IDLE)
      pre_cnt <= 3'd1;
    else if (state == PREAMBLE && gmii_rx_dv && gmii_rxd == ETH_PREAMBLE && pre_cnt != 3'd7)
      pre_cnt <= pre_cnt + 3'd1;
  end

  // header byte counter, shift register and EtherType capture
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      hdr_cnt     <= '0;
      hdr_sh      <= '0;
      rx_eth_type <= '0;
    end else begin
      if (sfd_hit)       hdr_cnt <= '0;
      else if (hdr_take) hdr_cnt <= hdr_cnt + 4'd1;
      if (hdr_take) hdr_sh <= {hdr_sh[31:0], gmii_rxd};
      if (hdr_take && hdr_cnt == 4'd13) rx_eth_type <= {hdr_sh[7:0], gmii_rxd};
    end
  end

  // payload delay line; the 4 bytes still held when dv drops are the FCS
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      dly     <= '0;
      dly_cnt <= '0;
    end else begin
      if (sfd_hit) dly_cnt <= '0;
      else if (pay_take && !dly_full) dly_cnt <= dly_cnt + 3'd1;
      if (pay_take) dly <= {dly[3:0], gmii_rxd};
    end
  end

  // frame length (runt detection) and payload beat counters
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      frm_cnt  <= '0;
      beat_cnt <= '0;
      beat_sat <= 1'b0;
    end else if (sfd_hit) begin
      frm_cnt  <= '0;
      beat_cnt <= '0;
      beat_sat <= 1'b0;
    end else begin
      if ((hdr_take || pay_take) && runt) frm_cnt <= frm_cnt + 7'd1;
      if (beat) begin
        if (beat_cnt == '1) beat_sat <= 1'b1;
        else                beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc;

  crc32_d8 u_crc (
    .clk  (gmii_rx_clk),
    .rst  (rst),
    .clr  (sfd_hit),
    .en   (hdr_take || pay_take),
    .data (gmii_rxd),
    .crc  (crc)
  );

  assign crc_bad = (crc != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // registered payload stream and end-of-frame status
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_sop      <= 1'b0;
      rx_eop      <= 1'b0;
      rx_done     <= 1'b0;
      rx_err      <= 1'b0;
      rx_byte_num <= '0;
    end else begin
      rx_valid <= beat;
      rx_data  <= beat ? dly[4] : '0;
      rx_sop   <= beat && (beat_cnt == '0);
      rx_eop   <= last_beat;
      rx_done  <= pay_end;
      rx_err   <= pay_end && (!dly_full || runt || beat_sat ||
                              (last_beat && beat_cnt == '1) || crc_bad);
      if (pay_end)
        rx_byte_num <= beat_cnt + {15'd0, (last_beat && beat_cnt != '1)};
    end
  end

endmodule
